add_accum_unit: RTL and testbench
=================================

ADD_ACCUM_UNIT -- requirements
Module: add_accum_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 4, operand/result width in bits (legal range 2..16).
REQ-002 SHALL have parameter CNT_W, default 8, width of the completed-transaction counter.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  operand beat valid.
REQ-006 SHALL have port in_ready  output  1  unit accepts a beat this cycle.
REQ-007 SHALL have port op  input  2  opcode: 00 ADD, 01 SUB, 10 ACC, 11 CLR.
REQ-008 SHALL have port sat  input  1  1 = saturating arithmetic, 0 = wrap-around; sampled with the operands.
REQ-009 SHALL have ports a and b  input  WIDTH  unsigned operands.
REQ-010 SHALL have port out_valid  output  1  result beat valid.
REQ-011 SHALL have port out_ready  input  1  downstream accepts the result.
REQ-012 SHALL have port result  output  WIDTH  operation result.
REQ-013 SHALL have port carry  output  1  carry (ADD/ACC) or borrow (SUB) of this beat.
REQ-014 SHALL have port ovf  output  1  sticky overflow flag.
REQ-015 SHALL have port acc  output  WIDTH  accumulator value.
REQ-016 SHALL have port count  output  CNT_W  completed output handshakes, wraps modulo 2^CNT_W.

Function
REQ-017 SHALL accept a beat when in_valid and in_ready are both 1 on a rising clk edge.
REQ-018 SHALL be a two-stage pipeline: stage 1 registers op/sat/a/b; stage 2 computes and registers result/carry/acc.
REQ-019 SHALL present out_valid two cycles after acceptance when never stalled; sustained throughput one beat per cycle.
REQ-020 SHALL define stall = out_valid AND NOT out_ready; during stall both stages hold and in_ready = 0 (combinational from out_ready).
REQ-021 SHALL hold result, carry and out_valid stable while stalled.
REQ-022 ADD: result = a + b; carry = bit WIDTH of the full sum; when sat=1 and carry=1, result = all ones.
REQ-023 SUB: result = a - b; carry = 1 when a < b; when sat=1 and carry=1, result = 0.
REQ-024 ACC: sum = acc + a + b computed WIDTH+2 bits wide; carry = 1 when sum > 2^WIDTH-1; acc and result take sum modulo 2^WIDTH, or all ones when sat=1 and carry=1.
REQ-025 CLR: acc = 0, result = 0, carry = 0, ovf cleared to 0.
REQ-026 acc SHALL change only when an ACC or CLR beat enters stage 2; ADD/SUB leave acc unchanged.
REQ-027 ovf SHALL set to 1 when any ADD/SUB/ACC beat entering stage 2 has carry = 1, and remain 1 until a CLR or reset.
REQ-028 Back-to-back ACC beats SHALL each use the acc produced by the previous beat (no hazard).
REQ-029 count SHALL increment by 1 on every cycle with out_valid and out_ready both 1, wrapping from all ones to 0.
REQ-030 Beats SHALL complete strictly in acceptance order; no beat is dropped or duplicated.

Reset
REQ-031 While reset = 0: out_valid = 0, in_ready = 0, result = 0, carry = 0, ovf = 0, acc = 0, count = 0, all stage-valid bits = 0.
REQ-032 Reset asserted mid-operation SHALL discard in-flight beats; in_ready = 1 from the first clk edge after reset deasserts.

Structure
REQ-033 A shared package add_accum_pkg SHALL hold the opcode enumeration (OP_ADD, OP_SUB, OP_ACC, OP_CLR) and the default WIDTH/CNT_W constants.
REQ-034 The saturating adder/subtractor (operands, mode, sat -> value, carry) SHALL be one sub-module, sat_addsub, instantiated in stage 2.

Verification (WIDTH=4, CNT_W=8)
REQ-035 ADD a=7, b=5, sat=0, out_ready=1 -> two cycles later result=12, carry=0; then a=9, b=9, sat=1 -> result=15, carry=1, ovf=1.
REQ-036 SUB a=3, b=5: sat=0 -> result=14, carry=1; sat=1 -> result=0, carry=1.
REQ-037 CLR, then ACC (a=4,b=3), ACC (a=6,b=2) back-to-back -> acc=7 then 15, carry=0; further ACC (1,0) sat=0 -> acc=0, carry=1, ovf=1; next CLR -> ovf=0.
REQ-038 Stream 5 beats, hold out_ready=0 for 3 cycles after the first out_valid -> in_ready=0 and result stable during stall; all 5 results delivered in order; count=5.
REQ-039 Assert reset with two beats in flight -> out_valid=0, acc=0, count=0 immediately; after release the next ADD 1+1 returns 2 with latency 2.
REQ-040 Perform 256 handshakes -> count wraps to 0.

Source files
------------

// File: rtl/add_accum_pkg.sv
// Shared definitions for the add/accumulate unit.
//   op_t       : opcode encoding carried through the pipeline
//   DEF_WIDTH  : default operand/result width
//   DEF_CNT_W  : default width of the completed-transaction counter
package add_accum_pkg;

   typedef enum logic [1:0] {
      OP_ADD = 2'b00,
      OP_SUB = 2'b01,
      OP_ACC = 2'b10,
      OP_CLR = 2'b11
   } op_t;

   localparam int DEF_WIDTH = 4;
   localparam int DEF_CNT_W = 8;

endpackage

// File: rtl/add_accum_unit_sat_addsub.sv
// Saturating adder/subtractor used by stage 2 of add_accum_unit.
//   x, y, z : unsigned operands (z is a third addend, ignored when sub=1)
//   sub     : 1 = x - y, 0 = x + y + z
//   sat     : 1 = clamp on carry/borrow, 0 = wrap-around
//   value   : WIDTH-bit result
//   carry   : carry out of the sum, or borrow of the difference
module sat_addsub
   import add_accum_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic [WIDTH-1:0] z,
   input  logic             sub,
   input  logic             sat,
   output logic [WIDTH-1:0] value,
   output logic             carry
);

   // Two guard bits: three full-scale addends never exceed 3*(2^WIDTH-1).
   logic [WIDTH+1:0] sum;
   logic [WIDTH:0]   diff;

   always_comb begin
      sum   = {2'b00, x} + {2'b00, y} + {2'b00, z};
      diff  = {1'b0, x} - {1'b0, y};
      value = '0;
      carry = 1'b0;
      if (sub) begin
         carry = diff[WIDTH];
         value = (sat && carry) ? '0 : diff[WIDTH-1:0];
      end else begin
         carry = |sum[WIDTH+1:WIDTH];
         value = (sat && carry) ? '1 : sum[WIDTH-1:0];
      end
   end

endmodule

// File: rtl/add_accum_unit.sv
// Two-stage add/subtract/accumulate unit with valid/ready handshakes.
//   clk, reset          : rising-edge clock, async active-low reset
//   in_valid / in_ready : operand beat handshake (op, sat, a, b)
//   out_valid/out_ready : result beat handshake (result, carry)
//   ovf                 : sticky overflow, cleared by CLR or reset
//   acc                 : accumulator, touched only by ACC and CLR
//   count               : completed output handshakes, wraps
module add_accum_unit
   import add_accum_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       op,
   input  logic             sat,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             carry,
   output logic             ovf,
   output logic [WIDTH-1:0] acc,
   output logic [CNT_W-1:0] count
);

   logic             alive;
   logic             stall;
   logic             s1_valid;
   op_t              s1_op;
   logic             s1_sat;
   logic [WIDTH-1:0] s1_a;
   logic [WIDTH-1:0] s1_b;
   logic [WIDTH-1:0] addend_c;
   logic [WIDTH-1:0] calc_value;
   logic             calc_carry;

   // A stalled output freezes the whole pipe, so nothing new may enter.
   assign stall    = out_valid & ~out_ready;
   assign in_ready = alive & ~stall;

   // Holds in_ready low until the first edge after reset release.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) alive <= 1'b0;
      else        alive <= 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s1_valid <= 1'b0;
         s1_op    <= OP_ADD;
         s1_sat   <= 1'b0;
         s1_a     <= '0;
         s1_b     <= '0;
      end else if (!stall) begin
         s1_valid <= in_valid & in_ready;
         if (in_valid && in_ready) begin
            s1_op  <= op_t'(op);
            s1_sat <= sat;
            s1_a   <= a;
            s1_b   <= b;
         end
      end
   end

   // ACC reads the registered acc; the previous ACC has already written it
   // by the time the next beat reaches stage 2, so no forwarding is needed.
   assign addend_c = (s1_op == OP_ACC) ? acc : '0;

   sat_addsub #(.WIDTH(WIDTH)) u_sat_addsub (
      .x     (s1_a),
      .y     (s1_b),
      .z     (addend_c),
      .sub   (s1_op == OP_SUB),
      .sat   (s1_sat),
      .value (calc_value),
      .carry (calc_carry)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_valid <= 1'b0;
         result    <= '0;
         carry     <= 1'b0;
         acc       <= '0;
         ovf       <= 1'b0;
      end else if (!stall) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            unique case (s1_op)
               OP_CLR: begin
                  result <= '0;
                  carry  <= 1'b0;
                  acc    <= '0;
                  ovf    <= 1'b0;
               end
               OP_ACC: begin
                  result <= calc_value;
                  carry  <= calc_carry;
                  acc    <= calc_value;
                  ovf    <= ovf | calc_carry;
               end
               default: begin
                  result <= calc_value;
                  carry  <= calc_carry;
                  ovf    <= ovf | calc_carry;
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                      count <= '0;
      else if (out_valid && out_ready) count <= count + CNT_W'(1);
   end

endmodule

// File: tb/tb_add_accum_unit.sv
// Self-checking bench for add_accum_unit (WIDTH=4, CNT_W=8).
module tb_add_accum_unit;

   localparam int W = 4;
   localparam int C = 8;

   logic         clk;
   logic         reset;
   logic         in_valid;
   logic         in_ready;
   logic [1:0]   op;
   logic         sat;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] result;
   logic         carry;
   logic         ovf;
   logic [W-1:0] acc;
   logic [C-1:0] count;

   add_accum_unit #(.WIDTH(W), .CNT_W(C)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .sat       (sat),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .carry     (carry),
      .ovf       (ovf),
      .acc       (acc),
      .count     (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]   op;
      logic         s;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] r;
      logic         c;
      logic [W-1:0] ac;
      logic         ov;
   } vec_t;

   typedef struct {
      logic [W-1:0] r;
      logic         c;
      logic [W-1:0] ac;
      logic         ov;
   } exp_t;

   int   vectors;
   int   miscompares;
   int   m_acc;
   bit   m_ovf;
   exp_t exp_q[$];

   vec_t tbl[15];
   vec_t bb[5];
   vec_t st[5];

   function automatic vec_t mk(int o, int s, int x, int y, int r, int c, int ac, int ov);
      vec_t v;
      v.op = 2'(o);
      v.s  = 1'(s);
      v.a  = W'(x);
      v.b  = W'(y);
      v.r  = W'(r);
      v.c  = 1'(c);
      v.ac = W'(ac);
      v.ov = 1'(ov);
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      vectors++;
      if (act !== expv) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d", name, act, expv);
      end
   endtask

   // Reference model: plain integer arithmetic on the opcode rules.
   task automatic model_push(input int o, input int s, input int x, input int y);
      int   full;
      int   r;
      int   c;
      exp_t e;
      full = 1 << W;
      case (o)
         0:       begin r = x + y;         c = (r >= full) ? 1 : 0; end
         1:       begin r = x - y;         c = (x < y) ? 1 : 0;     end
         2:       begin r = m_acc + x + y; c = (r >= full) ? 1 : 0; end
         default: begin r = 0;             c = 0;                   end
      endcase
      if (c != 0 && s != 0) r = (o == 1) ? 0 : full - 1;
      r = ((r % full) + full) % full;
      if (o == 2) m_acc = r;
      if (o == 3) begin
         m_acc = 0;
         m_ovf = 0;
      end else if (c != 0) begin
         m_ovf = 1;
      end
      e.r  = W'(r);
      e.c  = 1'(c);
      e.ac = W'(m_acc);
      e.ov = m_ovf;
      exp_q.push_back(e);
   endtask

   // Entered at posedge+1 with inputs driven; returns at the next posedge+1.
   task automatic tick(output bit fired);
      exp_t e;
      bit   out_fire;
      #3;
      fired    = in_valid && in_ready;
      out_fire = out_valid && out_ready;
      if (out_fire) begin
         if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_out: got result %0d, expected no beat", result);
         end else begin
            e = exp_q.pop_front();
            check("sb_result", result, e.r);
            check("sb_carry", carry, e.c);
            check("sb_acc", acc, e.ac);
            check("sb_ovf", ovf, e.ov);
         end
      end
      if (fired) model_push(int'(op), int'(sat), int'(a), int'(b));
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input int budget);
      bit f;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < budget && exp_q.size() > 0; i++) tick(f);
      check("drain_left", exp_q.size(), 0);
   endtask

   task automatic do_reset();
      reset     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      m_acc = 0;
      m_ovf = 0;
      exp_q.delete();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_single(input vec_t v, input string tag);
      in_valid  = 1'b1;
      op        = v.op;
      sat       = v.s;
      a         = v.a;
      b         = v.b;
      out_ready = 1'b1;
      #3 check({tag, "_in_ready"}, in_ready, 1);
      @(posedge clk);
      #1 in_valid = 1'b0;
      check({tag, "_early_valid"}, out_valid, 0);
      @(posedge clk);
      #1;
      check({tag, "_valid"}, out_valid, 1);
      check({tag, "_result"}, result, v.r);
      check({tag, "_carry"}, carry, v.c);
      check({tag, "_acc"}, acc, v.ac);
      check({tag, "_ovf"}, ovf, v.ov);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit f;
      int idx;
      int stall_left;
      bit stalled;
      int accepted;

      vectors     = 0;
      miscompares = 0;
      m_acc       = 0;
      m_ovf       = 0;

      //            op s  a  b   r  c ac ov
      tbl[0]  = mk(3, 0, 0, 0,  0, 0, 0, 0);
      tbl[1]  = mk(0, 0, 7, 5, 12, 0, 0, 0);
      tbl[2]  = mk(0, 1, 9, 9, 15, 1, 0, 1);
      tbl[3]  = mk(1, 0, 3, 5, 14, 1, 0, 1);
      tbl[4]  = mk(1, 1, 3, 5,  0, 1, 0, 1);
      tbl[5]  = mk(3, 0, 0, 0,  0, 0, 0, 0);
      tbl[6]  = mk(2, 0, 4, 3,  7, 0, 7, 0);
      tbl[7]  = mk(2, 0, 6, 2, 15, 0, 15, 0);
      tbl[8]  = mk(2, 0, 1, 0,  0, 1, 0, 1);
      tbl[9]  = mk(3, 0, 0, 0,  0, 0, 0, 0);
      tbl[10] = mk(2, 1, 15, 15, 15, 1, 15, 1);
      tbl[11] = mk(2, 0, 15, 15, 13, 1, 13, 1);
      tbl[12] = mk(0, 0, 15, 1,  0, 1, 13, 1);
      tbl[13] = mk(1, 1, 9, 9,  0, 0, 13, 1);
      tbl[14] = mk(3, 0, 0, 0,  0, 0, 0, 0);

      bb[0] = mk(3, 0, 0, 0, 0, 0, 0, 0);
      bb[1] = mk(2, 0, 4, 3, 0, 0, 0, 0);
      bb[2] = mk(2, 0, 6, 2, 0, 0, 0, 0);
      bb[3] = mk(2, 0, 1, 0, 0, 0, 0, 0);
      bb[4] = mk(3, 0, 0, 0, 0, 0, 0, 0);

      st[0] = mk(0, 0, 1, 2, 0, 0, 0, 0);
      st[1] = mk(0, 0, 3, 4, 0, 0, 0, 0);
      st[2] = mk(0, 0, 5, 6, 0, 0, 0, 0);
      st[3] = mk(1, 0, 9, 2, 0, 0, 0, 0);
      st[4] = mk(0, 1, 8, 9, 0, 0, 0, 0);

      // Reset values while reset is held.
      reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      op = 2'b00; sat = 1'b0; a = '0; b = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready", in_ready, 0);
      check("rst_result", result, 0);
      check("rst_carry", carry, 0);
      check("rst_ovf", ovf, 0);
      check("rst_acc", acc, 0);
      check("rst_count", count, 0);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1 check("rel_in_ready", in_ready, 1);

      // Single-beat table with latency checks.
      for (int i = 0; i < 15; i++) apply_single(tbl[i], $sformatf("vec%0d", i));

      // Back-to-back ACC beats through the scoreboard.
      idx = 0;
      out_ready = 1'b1;
      for (int cyc = 0; cyc < 40 && idx < 5; cyc++) begin
         in_valid = 1'b1;
         op = bb[idx].op; sat = bb[idx].s; a = bb[idx].a; b = bb[idx].b;
         tick(f);
         if (f) idx++;
      end
      check("b2b_accepted", idx, 5);
      drain(20);

      // Five-beat stream with a three-cycle output stall.
      do_reset();
      idx = 0; stall_left = 0; stalled = 1'b0;
      for (int cyc = 0; cyc < 60 && (idx < 5 || exp_q.size() > 0); cyc++) begin
         if (!stalled && out_valid) begin
            stalled    = 1'b1;
            stall_left = 3;
         end
         out_ready = (stall_left == 0);
         in_valid  = (idx < 5);
         if (idx < 5) begin
            op = st[idx].op; sat = st[idx].s; a = st[idx].a; b = st[idx].b;
         end
         if (stall_left > 0) begin
            #1;
            check("stall_in_ready", in_ready, 0);
            check("stall_out_valid", out_valid, 1);
            if (exp_q.size() > 0) check("stall_result", result, exp_q[0].r);
            stall_left--;
         end
         tick(f);
         if (f) idx++;
      end
      check("stall_seen", stalled, 1);
      check("stall_left_q", exp_q.size(), 0);
      check("stall_count", count, 5);

      // Reset with two beats in flight.
      in_valid = 1'b1; out_ready = 1'b1; sat = 1'b0;
      op = 2'b10; a = 4'd5; b = 4'd5;
      tick(f);
      op = 2'b00; a = 4'd1; b = 4'd2;
      tick(f);
      op = 2'b00; a = 4'd3; b = 4'd3;
      tick(f);
      in_valid = 1'b0;
      check("pre_rst_acc", acc, 10);
      check("pre_rst_valid", out_valid, 1);
      reset = 1'b0;
      #1;
      check("mid_rst_out_valid", out_valid, 0);
      check("mid_rst_acc", acc, 0);
      check("mid_rst_count", count, 0);
      check("mid_rst_in_ready", in_ready, 0);
      m_acc = 0; m_ovf = 0; exp_q.delete();
      @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      #1 check("post_rel_in_ready_low", in_ready, 0);
      @(posedge clk);
      #1 check("post_rel_in_ready", in_ready, 1);
      apply_single(mk(0, 0, 1, 1, 2, 0, 0, 0), "post_rst_add");

      // Randomized traffic: 256 accepted beats, so count wraps to 0.
      do_reset();
      accepted = 0;
      for (int cyc = 0; cyc < 3000 && accepted < 256; cyc++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         op  = 2'($urandom_range(0, 3));
         sat = 1'($urandom_range(0, 1));
         a   = W'($urandom_range(0, 15));
         b   = W'($urandom_range(0, 15));
         tick(f);
         if (f) accepted++;
      end
      check("rand_accepted", accepted, 256);
      drain(50);
      check("count_wrap", count, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
